// File: rtl/control_unit.sv
// control_unit -- fetch/decode/execute sequencer for the 16-bit accumulator
// machine. Holds PC, IR, MAR, MBR and AC, drives the synchronous-read main
// memory port and the combinational ALU, and runs one instruction at a time
// from reset until HALT (or an undefined opcode).
//
// Optional feature macro: CU_LOADI_EN
//   defined   : opcode 0xB is LOADI (AC = M[M[X][11:0]])
//   undefined : opcode 0xB is illegal; the indirect path is not built
//
// Ports:
//   clk         system clock, all state on posedge
//   reset       synchronous, active-high
//   mem_addr    memory address {4'b0, addr12}
//   mem_wdata   memory write data (always AC)
//   mem_we      memory write enable (only in S_WRITE, forced 0 in reset)
//   mem_rdata   memory read data, valid the cycle after the address
//   alu_opcode  ALU operation select
//   alu_a       ALU operand 1 (AC)
//   alu_b       ALU operand 2 (MBR)
//   alu_result  ALU result, combinational
//   pc, ac, ir  architectural register views
//   halted      high while in S_HALT
//   illegal     sticky undefined-opcode flag
//
// state     | meaning
// S_FETCH   | present PC on the memory address
// S_LOADIR  | capture IR from memory, increment PC
// S_DECODE  | latch MAR, execute single-cycle ops, dispatch others
// S_READ    | present MAR on the memory address
// S_LOADMBR | capture MBR (LOADI first pass: chase the pointer)
// S_EXEC    | write AC from MBR or the ALU
// S_WRITE   | store AC to M[MAR]
// S_HALT    | terminal until reset

module control_unit (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [11:0] pc,
  output logic [15:0] ac,
  output logic [15:0] ir,
  output logic        halted,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_LOADIR  = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_LOADMBR = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;
  localparam logic [3:0] OP_LOADI = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  logic [2:0]  state;
  logic [11:0] mar;
  logic [15:0] mbr;
  logic [3:0]  opcode;
  logic        skip_taken;

`ifdef CU_LOADI_EN
  logic        indirect;
`endif

  assign opcode = ir[15:12];

  always_comb begin
    skip_taken = 1'b0;
    case (ir[11:10])
      2'b00:   skip_taken = ac[15];
      2'b01:   skip_taken = (ac == 16'h0000);
      2'b10:   skip_taken = !ac[15] && (ac != 16'h0000);
      default: skip_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_opcode = ALU_ADD;
    case (opcode)
      OP_SUBT: alu_opcode = ALU_SUB;
      OP_AND:  alu_opcode = ALU_AND;
      OP_OR:   alu_opcode = ALU_OR;
      default: alu_opcode = ALU_ADD;
    endcase
  end

  assign mem_addr  = ((state == S_READ) || (state == S_WRITE)) ? {4'b0000, mar}
                                                                : {4'b0000, pc};
  // Combinational gate on reset so a write in flight is suppressed the
  // same cycle reset is asserted, not one edge later.
  assign mem_we    = (state == S_WRITE) && !reset;
  assign mem_wdata = ac;
  assign alu_a     = ac;
  assign alu_b     = mbr;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= 12'h000;
      ac      <= 16'h0000;
      ir      <= 16'h0000;
      mar     <= 12'h000;
      mbr     <= 16'h0000;
      illegal <= 1'b0;
`ifdef CU_LOADI_EN
      indirect <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: state <= S_LOADIR;

        S_LOADIR: begin
          ir    <= mem_rdata;
          pc    <= pc + 12'd1;
          state <= S_DECODE;
        end

        S_DECODE: begin
          mar <= ir[11:0];
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR: state <= S_READ;
`ifdef CU_LOADI_EN
            OP_LOADI: state <= S_READ;
`endif
            OP_STORE: state <= S_WRITE;
            OP_NOP:   state <= S_FETCH;
            OP_JUMP: begin
              pc    <= ir[11:0];
              state <= S_FETCH;
            end
            OP_CLEAR: begin
              ac    <= 16'h0000;
              state <= S_FETCH;
            end
            OP_SKIP: begin
              if (skip_taken) pc <= pc + 12'd1;
              state <= S_FETCH;
            end
            OP_HALT: state <= S_HALT;
            default: begin
              illegal <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end

        S_READ: state <= S_LOADMBR;

        S_LOADMBR: begin
          mbr <= mem_rdata;
`ifdef CU_LOADI_EN
          // First LOADI pass fetched the pointer; go read its target.
          if ((opcode == OP_LOADI) && !indirect) begin
            mar      <= mem_rdata[11:0];
            indirect <= 1'b1;
            state    <= S_READ;
          end else begin
            state <= S_EXEC;
          end
`else
          state <= S_EXEC;
`endif
        end

        S_EXEC: begin
          case (opcode)
            OP_LOAD: ac <= mbr;
`ifdef CU_LOADI_EN
            OP_LOADI: ac <= mbr;
`endif
            OP_ADD, OP_SUBT, OP_AND, OP_OR: ac <= alu_result;
            default: ac <= ac;
          endcase
`ifdef CU_LOADI_EN
          indirect <= 1'b0;
`endif
          state <= S_FETCH;
        end

        S_WRITE: state <= S_FETCH;

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [11:0] pc;
  logic [15:0] ac, ir;
  logic        halted, illegal;

  control_unit dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .pc(pc), .ac(ac), .ir(ir), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  // Synchronous-read memory; bench loads go through the same process.
  logic [15:0] mem [0:4095];
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[11:0]];
    if (ld_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: memory writes and halt events
  typedef struct {
    bit          is_halt;
    logic [11:0] addr;   // write address, or halt pc
    logic [15:0] data;   // write data, or halt ac
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  logic prev_halted = 1'b0;

  task automatic exp_write(input logic [11:0] a, input logic [15:0] d);
    exp_t e;
    e.is_halt = 1'b0; e.addr = a; e.data = d; e.ill = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_halt(input logic [11:0] p, input logic [15:0] a, input logic il);
    exp_t e;
    e.is_halt = 1'b1; e.addr = p; e.data = a; e.ill = il;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {4'h0, mem_addr[11:0], mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_is_write", {31'd0, e.is_halt}, 32'd0);
        check("write_addr", mem_addr, {4'h0, e.addr});
        check("write_data", mem_wdata, e.data);
      end
    end
    if (halted && !prev_halted) begin
      if (exp_q.size() == 0) begin
        check("unexpected_halt", {20'd0, pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_is_halt", {31'd0, e.is_halt}, 32'd1);
        check("halt_pc", pc, e.addr);
        check("halt_ac", ac, e.data);
        check("halt_illegal", illegal, e.ill);
      end
    end
    prev_halted <= halted;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_reset();
    @(posedge clk); #1;
    reset  = 1'b1;
    ld_clr = 1'b1;
    step(1);
    ld_clr = 1'b0;
  endtask

  task automatic mw(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    step(1);
    ld_en = 1'b0;
  endtask

  task automatic release_reset();
    step(1);
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input int max, output int cycles);
    cycles = 0;
    while (!halted && cycles < max) begin
      step(1);
      cycles++;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic drain();
    step(2);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;

    // Program: LOAD/ADD/STORE/HALT
    begin_reset();
    mw(12'h000, 16'h1010); mw(12'h001, 16'h3011);
    mw(12'h002, 16'h2012); mw(12'h003, 16'h7000);
    mw(12'h010, 16'd5);    mw(12'h011, 16'd7);
    check("rst_pc", pc, 12'h000);
    check("rst_ac", ac, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    exp_write(12'h012, 16'd12);
    exp_halt(12'd4, 16'd12, 1'b0);
    release_reset();
    check("first_fetch_addr", mem_addr, 16'h0000);
    run_until_halt(200, cyc);
    check("prog_halt_cycles", cyc, 19);
    check("prog_mem12", mem[12'h012], 16'd12);
    drain();

    // SUBT to zero, then SKIPCOND AC==0 skips the HALT at 3
    begin_reset();
    mw(12'h000, 16'h1010); mw(12'h001, 16'h4011);
    mw(12'h002, 16'h8400); mw(12'h003, 16'h7000);
    mw(12'h004, 16'h2012); mw(12'h005, 16'h7000);
    mw(12'h010, 16'd3);    mw(12'h011, 16'd3);
    exp_write(12'h012, 16'h0000);
    exp_halt(12'd6, 16'h0000, 1'b0);
    release_reset();
    run_until_halt(200, cyc);
    check("subt_halt_cycles", cyc, 22);
    drain();

    // Skip modes, OR/AND, CLEAR
    begin_reset();
    mw(12'h000, 16'h1010); mw(12'h001, 16'h8000); mw(12'h002, 16'h7000);
    mw(12'h003, 16'h8800); mw(12'h004, 16'h2020); mw(12'h005, 16'h8C00);
    mw(12'h006, 16'h2021); mw(12'h007, 16'h8400); mw(12'h008, 16'h6011);
    mw(12'h009, 16'h5012); mw(12'h00A, 16'h8800); mw(12'h00B, 16'h7000);
    mw(12'h00C, 16'hA000); mw(12'h00D, 16'h2022); mw(12'h00E, 16'h7000);
    mw(12'h010, 16'h8000); mw(12'h011, 16'h00F0); mw(12'h012, 16'h0FFF);
    exp_write(12'h020, 16'h8000);
    exp_write(12'h021, 16'h8000);
    exp_write(12'h022, 16'h0000);
    exp_halt(12'd15, 16'h0000, 1'b0);
    release_reset();
    run_until_halt(400, cyc);
    check("mix_halt_cycles", cyc, 51);
    drain();

    // Illegal opcode
    begin_reset();
    mw(12'h000, 16'hF123);
    exp_halt(12'd1, 16'h0000, 1'b1);
    release_reset();
    run_until_halt(50, cyc);
    check("ill_halt_cycles", cyc, 3);
    step(10);
    check("ill_pc_hold", pc, 12'd1);
    check("ill_ir_hold", ir, 16'hF123);
    check("ill_still_halted", halted, 1'b1);
    drain();

    // LOADI
    begin_reset();
    mw(12'h000, 16'hB020); mw(12'h001, 16'h7000);
    mw(12'h020, 16'h0030); mw(12'h030, 16'hBEEF);
`ifdef CU_LOADI_EN
    exp_halt(12'd2, 16'hBEEF, 1'b0);
    release_reset();
    step(8);
    check("loadi_ac_8cyc", ac, 16'hBEEF);
    run_until_halt(50, cyc);
`else
    exp_halt(12'd1, 16'h0000, 1'b1);
    release_reset();
    run_until_halt(50, cyc);
    check("loadi_off_cycles", cyc, 3);
`endif
    drain();

    // PC wrap: JUMP 0xFFF then NOP at 0xFFF
    begin_reset();
    mw(12'h000, 16'h9FFF); mw(12'hFFF, 16'h0000);
    release_reset();
    step(3);
    check("wrap_jump_addr", mem_addr, 16'h0FFF);
    check("wrap_jump_pc", pc, 12'hFFF);
    step(3);
    check("wrap_fetch_addr", mem_addr, 16'h0000);
    check("wrap_pc", pc, 12'h000);

    // Reset during S_WRITE of STORE 0x012 with AC=0x1234
    begin_reset();
    mw(12'h000, 16'h1010); mw(12'h001, 16'h2012);
    mw(12'h010, 16'h1234); mw(12'h012, 16'hAAAA);
    release_reset();
    step(9);
    check("wr_we_before_reset", mem_we, 1'b1);
    check("wr_addr_before_reset", mem_addr, 16'h0012);
    check("wr_ac_before_reset", ac, 16'h1234);
    reset = 1'b1;
    #1;
    check("wr_we_forced_low", mem_we, 1'b0);
    step(1);
    check("wr_rst_pc", pc, 12'h000);
    check("wr_rst_ac", ac, 16'h0000);
    step(1);
    check("wr_mem_unchanged", mem[12'h012], 16'hAAAA);
    check("wr_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
